sdram_arbit: RTL and testbench

Central arbiter and command multiplexer of the SDRAM controller. It receives service requests from the refresh, write and read engines and grants one engine at a time via a per-engine enable. It holds each grant until that engine's end flag, then steers the granted engine's command, address and bank onto the SDRAM pins. Initialization owns the bus until it completes.

---
 rtl/sdram_pkg.sv | 18 +
 rtl/sdram_arbit.sv | 96 +++++++++
 tb/tb_sdram_arbit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command constants and arbiter state encoding
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PALL = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

endpackage

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM engine arbiter and command/address pin multiplexer
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111,
    parameter int          ADDR_W = 13,
    parameter int          BA_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              flag_aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic              rd_req,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba
);
    import sdram_pkg::*;

    logic [2:0] state;
    logic [2:0] state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Each grant always passes back through ARBIT, so no two grants are adjacent.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (flag_init_end) state_nxt = ST_ARBIT;
            ST_ARBIT: begin
                if (aref_req)      state_nxt = ST_AREF;
                else if (wr_req)   state_nxt = ST_WRITE;
                else if (rd_req)   state_nxt = ST_READ;
            end
            ST_AREF:  if (flag_aref_end) state_nxt = ST_ARBIT;
            ST_WRITE: if (flag_wr_end)   state_nxt = ST_ARBIT;
            ST_READ:  if (flag_rd_end)   state_nxt = ST_ARBIT;
            default:  state_nxt = ST_INIT;
        endcase
    end

    assign aref_en   = (state == ST_AREF);
    assign wr_en     = (state == ST_WRITE);
    assign rd_en     = (state == ST_READ);
    assign sdram_cke = 1'b1;

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
        case (state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_ba;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed self-checking bench for sdram_arbit
module tb_sdram_arbit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_init_end;
    logic [3:0]  init_cmd;
    logic [12:0] init_addr;
    logic        aref_req, flag_aref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic        wr_req, flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [1:0]  wr_ba;
    logic        rd_req, flag_rd_end;
    logic [3:0]  rd_cmd;
    logic [12:0] rd_addr;
    logic [1:0]  rd_ba;
    logic        aref_en, wr_en, rd_en, sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;

    int checks = 0;
    int errors = 0;

    sdram_arbit dut (
        .clk(clk), .rst_n(rst_n), .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .flag_aref_end(flag_aref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd),
        .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] en, input logic [3:0] cmd,
                           input logic [12:0] addr, input logic [1:0] ba);
        chk({tag, ".en"},   {13'd0, aref_en, wr_en, rd_en}, {13'd0, en});
        chk({tag, ".cke"},  {15'd0, sdram_cke}, 16'd1);
        chk({tag, ".cmd"},  {12'd0, sdram_cmd}, {12'd0, cmd});
        chk({tag, ".addr"}, {3'd0, sdram_addr}, {3'd0, addr});
        chk({tag, ".ba"},   {14'd0, sdram_ba}, {14'd0, ba});
    endtask

    initial begin
        rst_n = 1'b0;
        flag_init_end = 1'b0;
        init_cmd = 4'b0111; init_addr = 13'h0000;
        aref_req = 1'b0; flag_aref_end = 1'b0;
        aref_cmd = 4'b0001; aref_addr = 13'h1abc;
        wr_req = 1'b0; flag_wr_end = 1'b0;
        wr_cmd = 4'b0100; wr_addr = 13'h0123; wr_ba = 2'b01;
        rd_req = 1'b0; flag_rd_end = 1'b0;
        rd_cmd = 4'b0101; rd_addr = 13'h0400; rd_ba = 2'b10;

        tick(); tick();
        init_cmd = 4'b0010; init_addr = 13'h0400;
        #1 chk_all("reset", 3'b000, 4'b0010, 13'h0400, 2'b00);

        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            init_cmd  = 4'(i);
            init_addr = 13'(i * 3);
            tick();
            chk_all("init_hold", 3'b000, 4'(i), 13'(i * 3), 2'b00);
        end

        flag_init_end = 1'b1;
        tick();
        chk_all("arbit_idle", 3'b000, 4'b0111, 13'h0000, 2'b00);
        tick();
        chk_all("arbit_stay", 3'b000, 4'b0111, 13'h0000, 2'b00);

        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk_all("aref_prio", 3'b100, 4'b0001, 13'h1abc, 2'b00);
        aref_req = 1'b0;
        flag_init_end = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_all("aref_hold", 3'b100, 4'b0001, 13'h1abc, 2'b00);
        end
        flag_aref_end = 1'b1;
        tick();
        chk_all("aref_release", 3'b000, 4'b0111, 13'h0000, 2'b00);
        flag_aref_end = 1'b0;
        tick();
        chk_all("wr_after_aref", 3'b010, 4'b0100, 13'h0123, 2'b01);
        wr_req = 1'b0;
        tick();
        chk_all("wr_hold", 3'b010, 4'b0100, 13'h0123, 2'b01);

        aref_req = 1'b1;
        tick();
        chk_all("no_preempt", 3'b010, 4'b0100, 13'h0123, 2'b01);
        flag_wr_end = 1'b1;
        tick();
        chk_all("wr_early_end", 3'b000, 4'b0111, 13'h0000, 2'b00);
        flag_wr_end = 1'b0; wr_req = 1'b1;
        tick();
        chk_all("aref_over_wr", 3'b100, 4'b0001, 13'h1abc, 2'b00);
        aref_req = 1'b0;
        flag_wr_end = 1'b1;
        tick();
        chk_all("wr_end_in_aref", 3'b100, 4'b0001, 13'h1abc, 2'b00);
        flag_wr_end = 1'b0; flag_aref_end = 1'b1;
        tick();
        chk_all("aref2_release", 3'b000, 4'b0111, 13'h0000, 2'b00);
        flag_aref_end = 1'b0;
        tick();
        chk_all("wr_resume", 3'b010, 4'b0100, 13'h0123, 2'b01);
        wr_req = 1'b0;

        flag_rd_end = 1'b1;
        tick();
        chk_all("rd_end_in_wr", 3'b010, 4'b0100, 13'h0123, 2'b01);
        flag_rd_end = 1'b0;

        // End flag together with a competing request: ARBIT first, then grant.
        flag_wr_end = 1'b1; rd_req = 1'b1;
        tick();
        chk_all("end_with_req", 3'b000, 4'b0111, 13'h0000, 2'b00);
        flag_wr_end = 1'b0;
        tick();
        chk_all("rd_grant", 3'b001, 4'b0101, 13'h0400, 2'b10);
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("rd_mirror", 3'b001, 4'b0101, 13'h0400, 2'b10);
        end
        flag_aref_end = 1'b1;
        tick();
        chk_all("aref_end_in_rd", 3'b001, 4'b0101, 13'h0400, 2'b10);
        flag_aref_end = 1'b0; flag_rd_end = 1'b1;
        tick();
        chk_all("rd_release", 3'b000, 4'b0111, 13'h0000, 2'b00);
        flag_rd_end = 1'b0;
        tick();
        chk_all("idle_again", 3'b000, 4'b0111, 13'h0000, 2'b00);

        wr_req = 1'b1;
        tick();
        chk_all("wr_before_rst", 3'b010, 4'b0100, 13'h0123, 2'b01);
        wr_req = 1'b0;
        #2 rst_n = 1'b0;
        init_cmd = 4'b0010; init_addr = 13'h0400;
        #1 chk_all("async_reset", 3'b000, 4'b0010, 13'h0400, 2'b00);
        tick();
        rst_n = 1'b1;
        tick();
        chk_all("init_after_rst", 3'b000, 4'b0010, 13'h0400, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
